// File: rtl/maj_bist_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : maj_bist_sequencer
// Purpose  : Hardware self-test for an N_IN-input majority gate. Sweeps every
//            input code, holds it SETTLE_CYCLES clocks, then checks the result.
// Revision : 1.0 - initial release
// ============================================================================
module maj_bist_sequencer #(
   parameter int N_IN          = 3,
   parameter int SETTLE_CYCLES = 4
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start_i,
   output logic [N_IN-1:0] dut_in_o,
   input  logic            dut_out_i,
   output logic            busy_o,
   output logic            done_o,
   output logic            pass_o,
   output logic [N_IN:0]   err_count_o,
   output logic [N_IN-1:0] first_fail_o,
   output logic            fail_seen_o
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SETTLE = 2'd1,
      S_CHECK  = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   localparam logic [N_IN-1:0] C_ALL_ONES = '1;
   localparam logic [7:0]      C_LAST_CNT = 8'(SETTLE_CYCLES - 1);
   localparam logic [N_IN:0]   C_ERR_MAX  = {1'b1, {N_IN{1'b0}}};

   state_t          state_q, state_d;
   logic [N_IN-1:0] dut_in_q, dut_in_d;
   logic [7:0]      cnt_q, cnt_d;
   logic [N_IN:0]   err_q, err_d;
   logic [N_IN-1:0] first_fail_q, first_fail_d;
   logic            fail_seen_q, fail_seen_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            pass_q, pass_d;

   int              ones;
   logic            expected;

   always_comb begin
      ones = 0;
      for (int i = 0; i < N_IN; i++) begin
         ones = ones + int'(dut_in_q[i]);
      end
      expected = (ones > (N_IN / 2));
   end

   always_comb begin
      state_d      = state_q;
      dut_in_d     = dut_in_q;
      cnt_d        = cnt_q;
      err_d        = err_q;
      first_fail_d = first_fail_q;
      fail_seen_d  = fail_seen_q;

      case (state_q)
         S_IDLE, S_DONE: begin
            if (start_i) begin
               state_d      = S_SETTLE;
               dut_in_d     = '0;
               cnt_d        = '0;
               err_d        = '0;
               first_fail_d = '0;
               fail_seen_d  = 1'b0;
            end
         end
         S_SETTLE: begin
            if (cnt_q == C_LAST_CNT) begin
               state_d = S_CHECK;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         S_CHECK: begin
            // Compare against the vector held during the window, before any increment.
            if (dut_out_i != expected) begin
               if (err_q != C_ERR_MAX) begin
                  err_d = err_q + 1'b1;
               end
               if (!fail_seen_q) begin
                  first_fail_d = dut_in_q;
                  fail_seen_d  = 1'b1;
               end
            end
            if (dut_in_q == C_ALL_ONES) begin
               state_d = S_DONE;
            end else begin
               dut_in_d = dut_in_q + 1'b1;
               cnt_d    = '0;
               state_d  = S_SETTLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Status flags are registered from the next state so they align with it.
      busy_d = (state_d == S_SETTLE) || (state_d == S_CHECK);
      done_d = (state_d == S_DONE);
      pass_d = (state_d == S_DONE) && (err_d == '0);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= S_IDLE;
         dut_in_q     <= '0;
         cnt_q        <= '0;
         err_q        <= '0;
         first_fail_q <= '0;
         fail_seen_q  <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         pass_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         dut_in_q     <= dut_in_d;
         cnt_q        <= cnt_d;
         err_q        <= err_d;
         first_fail_q <= first_fail_d;
         fail_seen_q  <= fail_seen_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         pass_q       <= pass_d;
      end
   end

   assign dut_in_o     = dut_in_q;
   assign busy_o       = busy_q;
   assign done_o       = done_q;
   assign pass_o       = pass_q;
   assign err_count_o  = err_q;
   assign first_fail_o = first_fail_q;
   assign fail_seen_o  = fail_seen_q;

endmodule
`default_nettype wire
